// File: rtl/lsu_stage.sv
// Memory-access stage between execute and write-back.
// It accepts one instruction per handshake. Loads and stores each run one
// AXI4-Lite-style transaction. Load data is aligned and then sign- or
// zero-extended. Misaligned accesses and bus errors raise exceptions.
// Port groups:
//   i_valid/o_ready - upstream handshake.
//   i_mem_*, i_result, i_reg_*, i_pc, i_exception, i_mcause - instruction fields.
//   AR/R/AW/W/B - read and write bus channels.
//   o_valid/i_ready and o_* - write-back bundle.
module lsu_stage #(
  parameter logic [3:0] MC_LD_MISALIGN = 4'd4,
  parameter logic [3:0] MC_LD_FAULT    = 4'd5,
  parameter logic [3:0] MC_ST_MISALIGN = 4'd6,
  parameter logic [3:0] MC_ST_FAULT    = 4'd7
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [3:0]  i_mem_wmask,
  input  logic [2:0]  i_mem_read_t,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [31:0] i_result,
  input  logic [4:0]  i_reg_rd,
  input  logic        i_reg_wen,
  input  logic [31:0] i_pc,
  input  logic        i_exception,
  input  logic [3:0]  i_mcause,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_awaddr,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_reg_rd,
  output logic        o_reg_wen,
  output logic [31:0] o_pc,
  output logic        o_exception,
  output logic [3:0]  o_mcause
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR, WR_B, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [3:0]  mcause_q, mcause_d;
  logic [2:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic        wen_q, wen_d;
  logic        exc_q, exc_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        accept;
  logic        ld_mis;
  logic        st_mis;
  logic        aw_fire;
  logic        w_fire;
  logic [4:0]  sh;
  logic [31:0] rshift;
  logic [31:0] ldata;

  assign o_ready = (state_q == IDLE) ||
                   (state_q == DONE && i_ready);
  assign accept  = i_valid && o_ready;

  // Access size comes from funct3 for loads and from the mask for stores.
  assign ld_mis =
    (i_mem_read_t[1:0] == 2'b01 && i_mem_addr[0]) ||
    (i_mem_read_t[1:0] == 2'b10 && i_mem_addr[1:0] != 2'b00);
  assign st_mis =
    (i_mem_wmask == 4'b0011 && i_mem_addr[0]) ||
    (i_mem_wmask == 4'b1111 && i_mem_addr[1:0] != 2'b00);

  assign sh     = {addr_q[1:0], 3'b000};
  assign rshift = i_rdata >> sh;

  always_comb begin
    ldata = rshift;
    case (rt_q)
      3'b000:  ldata = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  ldata = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  ldata = {24'd0, rshift[7:0]};
      3'b101:  ldata = {16'd0, rshift[15:0]};
      default: ldata = rshift;
    endcase
  end

  assign o_arvalid = (state_q == RD_A);
  assign o_araddr  = addr_q;
  assign o_rready  = (state_q == RD_D);
  assign o_awvalid = (state_q == WR) && !aw_done_q;
  assign o_wvalid  = (state_q == WR) && !w_done_q;
  assign o_awaddr  = addr_q;
  assign o_wdata   = wdata_q << sh;
  assign o_wstrb   = wmask_q << addr_q[1:0];
  assign o_bready  = (state_q == WR_B);
  assign aw_fire   = o_awvalid && i_awready;
  assign w_fire    = o_wvalid && i_wready;

  assign o_valid     = (state_q == DONE);
  assign o_result    = result_q;
  assign o_reg_rd    = rd_q;
  assign o_reg_wen   = wen_q;
  assign o_pc        = pc_q;
  assign o_exception = exc_q;
  assign o_mcause    = mcause_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    result_d  = result_q;
    pc_d      = pc_q;
    wmask_d   = wmask_q;
    mcause_d  = mcause_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    exc_d     = exc_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      IDLE: ;
      RD_A: begin
        if (i_arready) state_d = RD_D;
      end
      RD_D: begin
        if (i_rvalid) begin
          result_d = ldata;
          state_d  = DONE;
          if (i_rresp != 2'b00) begin
            exc_d    = 1'b1;
            mcause_d = MC_LD_FAULT;
            wen_d    = 1'b0;
          end
        end
      end
      WR: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_B: begin
        if (i_bvalid) begin
          state_d = DONE;
          if (i_bresp != 2'b00) begin
            exc_d    = 1'b1;
            mcause_d = MC_ST_FAULT;
          end
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new instruction overrides DONE->IDLE for back-to-back issue.
    if (accept) begin
      addr_d    = i_mem_addr;
      wdata_d   = i_mem_wdata;
      wmask_d   = i_mem_wmask;
      rt_d      = i_mem_read_t;
      rd_d      = i_reg_rd;
      pc_d      = i_pc;
      result_d  = i_result;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      exc_d     = 1'b0;
      mcause_d  = 4'd0;
      wen_d     = i_reg_wen && !i_mem_wen;
      if (i_exception) begin
        exc_d    = 1'b1;
        mcause_d = i_mcause;
        wen_d    = 1'b0;
        state_d  = DONE;
      end else if (i_mem_ren && ld_mis) begin
        exc_d    = 1'b1;
        mcause_d = MC_LD_MISALIGN;
        wen_d    = 1'b0;
        state_d  = DONE;
      end else if (i_mem_wen && st_mis) begin
        exc_d    = 1'b1;
        mcause_d = MC_ST_MISALIGN;
        wen_d    = 1'b0;
        state_d  = DONE;
      end else if (i_mem_ren) begin
        state_d = RD_A;
      end else if (i_mem_wen) begin
        state_d = WR;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      pc_q      <= '0;
      wmask_q   <= '0;
      mcause_q  <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      exc_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      result_q  <= result_d;
      pc_q      <= pc_d;
      wmask_q   <= wmask_d;
      mcause_q  <= mcause_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      exc_q     <= exc_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage.
// Bus responses are driven by hand around each instruction.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid, o_ready;
  logic        i_mem_ren, i_mem_wen;
  logic [3:0]  i_mem_wmask;
  logic [2:0]  i_mem_read_t;
  logic [31:0] i_mem_addr, i_mem_wdata, i_result, i_pc;
  logic [4:0]  i_reg_rd;
  logic        i_reg_wen, i_exception;
  logic [3:0]  i_mcause;
  logic [31:0] o_araddr;
  logic        o_arvalid, i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid, o_rready;
  logic [31:0] o_awaddr;
  logic        o_awvalid, i_awready;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_wvalid, i_wready;
  logic [1:0]  i_bresp;
  logic        i_bvalid, o_bready;
  logic        o_valid, i_ready;
  logic [31:0] o_result, o_pc;
  logic [4:0]  o_reg_rd;
  logic        o_reg_wen, o_exception;
  logic [3:0]  o_mcause;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_stage dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen),
    .i_mem_wmask(i_mem_wmask), .i_mem_read_t(i_mem_read_t),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_result(i_result), .i_reg_rd(i_reg_rd),
    .i_reg_wen(i_reg_wen), .i_pc(i_pc),
    .i_exception(i_exception), .i_mcause(i_mcause),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata),
    .i_rresp(i_rresp), .i_rvalid(i_rvalid),
    .o_rready(o_rready), .o_awaddr(o_awaddr),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid),
    .o_bready(o_bready), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result),
    .o_reg_rd(o_reg_rd), .o_reg_wen(o_reg_wen),
    .o_pc(o_pc), .o_exception(o_exception),
    .o_mcause(o_mcause)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ren, input logic wen,
                       input logic [3:0] wm,
                       input logic [2:0] rt,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [31:0] res,
                       input logic [4:0] rd,
                       input logic rwen, input logic exc,
                       input logic [3:0] mc);
    i_valid      = 1'b1;
    i_mem_ren    = ren;
    i_mem_wen    = wen;
    i_mem_wmask  = wm;
    i_mem_read_t = rt;
    i_mem_addr   = addr;
    i_mem_wdata  = wd;
    i_result     = res;
    i_reg_rd     = rd;
    i_reg_wen    = rwen;
    i_exception  = exc;
    i_mcause     = mc;
    i_pc         = addr ^ 32'h0000_0100;
    #1;
    chk("issue_ready", o_ready, 1'b1);
    tick();
    i_valid = 1'b0;
  endtask

  // Drives AR after ar_delay stalled cycles, then R.
  task automatic rd_bus(input int ar_delay,
                        input logic [31:0] addr,
                        input logic [31:0] rdata,
                        input logic [1:0] rresp);
    for (int k = 0; k < ar_delay; k++) begin
      chk("ar_hold_valid", o_arvalid, 1'b1);
      chk("ar_hold_addr", o_araddr, addr);
      tick();
    end
    i_arready = 1'b1;
    #1;
    chk("ar_valid", o_arvalid, 1'b1);
    chk("ar_addr", o_araddr, addr);
    chk("rda_not_ready", o_ready, 1'b0);
    tick();
    i_arready = 1'b0;
    chk("ar_dropped", o_arvalid, 1'b0);
    chk("r_ready", o_rready, 1'b1);
    i_rvalid = 1'b1;
    i_rdata  = rdata;
    i_rresp  = rresp;
    tick();
    i_rvalid = 1'b0;
    i_rresp  = 2'b00;
    chk("rd_done_valid", o_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_valid = 0; i_mem_ren = 0; i_mem_wen = 0;
    i_mem_wmask = 0; i_mem_read_t = 0; i_mem_addr = 0;
    i_mem_wdata = 0; i_result = 0; i_reg_rd = 0;
    i_reg_wen = 0; i_pc = 0; i_exception = 0; i_mcause = 0;
    i_arready = 0; i_rdata = 0; i_rresp = 0; i_rvalid = 0;
    i_awready = 0; i_wready = 0; i_bresp = 0; i_bvalid = 0;
    i_ready = 1;

    #1;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_arvalid", o_arvalid, 1'b0);
    chk("rst_awvalid", o_awvalid, 1'b0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_regwen", o_reg_wen, 1'b0);
    chk("rst_exc", o_exception, 1'b0);
    #11 rst_n = 1'b1;
    tick();

    // Non-memory instruction, latency 1.
    issue(0, 0, 4'b0000, 3'b000, 32'h0, 32'h0,
          32'h1234, 5'd5, 1, 0, 4'd0);
    chk("alu_valid", o_valid, 1'b1);
    chk("alu_result", o_result, 32'h1234);
    chk("alu_rd", o_reg_rd, 5'd5);
    chk("alu_regwen", o_reg_wen, 1'b1);
    chk("alu_no_ar", o_arvalid, 1'b0);
    chk("alu_no_aw", o_awvalid, 1'b0);
    tick();
    chk("alu_idle", o_valid, 1'b0);

    // lb at byte 3, AR stalled 2 cycles.
    issue(1, 0, 4'b0000, 3'b000, 32'h8000_0003, 32'h0,
          32'h0, 5'd6, 1, 0, 4'd0);
    rd_bus(2, 32'h8000_0003, 32'h80FF_FFFF, 2'b00);
    chk("lb_result", o_result, 32'hFFFF_FF80);
    chk("lb_regwen", o_reg_wen, 1'b1);
    chk("lb_pc", o_pc, 32'h8000_0103);
    tick();

    // lhu at upper half.
    issue(1, 0, 4'b0000, 3'b101, 32'h8000_0002, 32'h0,
          32'h0, 5'd7, 1, 0, 4'd0);
    rd_bus(0, 32'h8000_0002, 32'hBEEF_1234, 2'b00);
    chk("lhu_result", o_result, 32'h0000_BEEF);
    tick();

    // lh misaligned: no AR, cause 4.
    issue(1, 0, 4'b0000, 3'b001, 32'h8000_0001, 32'h0,
          32'h0, 5'd7, 1, 0, 4'd0);
    chk("lhmis_valid", o_valid, 1'b1);
    chk("lhmis_no_ar", o_arvalid, 1'b0);
    chk("lhmis_exc", o_exception, 1'b1);
    chk("lhmis_cause", o_mcause, 4'd4);
    chk("lhmis_regwen", o_reg_wen, 1'b0);
    tick();

    // sb 0xAB at byte 1, W before AW.
    issue(0, 1, 4'b0001, 3'b000, 32'h8000_0001, 32'h0000_00AB,
          32'h0, 5'd8, 1, 0, 4'd0);
    chk("sb_awvalid", o_awvalid, 1'b1);
    chk("sb_wvalid", o_wvalid, 1'b1);
    chk("sb_awaddr", o_awaddr, 32'h8000_0001);
    chk("sb_wstrb", o_wstrb, 4'b0010);
    chk("sb_wdata", o_wdata, 32'h0000_AB00);
    i_wready = 1'b1;
    tick();
    i_wready = 1'b0;
    chk("sb_w_dropped", o_wvalid, 1'b0);
    chk("sb_aw_held", o_awvalid, 1'b1);
    chk("sb_no_bready", o_bready, 1'b0);
    i_awready = 1'b1;
    tick();
    i_awready = 1'b0;
    chk("sb_aw_dropped", o_awvalid, 1'b0);
    chk("sb_bready", o_bready, 1'b1);
    i_bvalid = 1'b1;
    tick();
    i_bvalid = 1'b0;
    chk("sb_valid", o_valid, 1'b1);
    chk("sb_regwen", o_reg_wen, 1'b0);
    chk("sb_exc", o_exception, 1'b0);
    tick();

    // sh at upper half, both channels ready together.
    issue(0, 1, 4'b0011, 3'b000, 32'h8000_0002, 32'h0000_1234,
          32'h0, 5'd8, 0, 0, 4'd0);
    chk("sh_wstrb", o_wstrb, 4'b1100);
    chk("sh_wdata", o_wdata, 32'h1234_0000);
    i_wready = 1'b1;
    i_awready = 1'b1;
    tick();
    i_wready = 1'b0;
    i_awready = 1'b0;
    chk("sh_bready", o_bready, 1'b1);
    i_bvalid = 1'b1;
    tick();
    i_bvalid = 1'b0;
    chk("sh_valid", o_valid, 1'b1);
    tick();

    // lw with read error.
    issue(1, 0, 4'b0000, 3'b010, 32'h8000_0004, 32'h0,
          32'h0, 5'd9, 1, 0, 4'd0);
    rd_bus(0, 32'h8000_0004, 32'hDEAD_BEEF, 2'b10);
    chk("lwerr_exc", o_exception, 1'b1);
    chk("lwerr_cause", o_mcause, 4'd5);
    chk("lwerr_regwen", o_reg_wen, 1'b0);
    tick();

    // sw with write error.
    issue(0, 1, 4'b1111, 3'b000, 32'h8000_0008, 32'hCAFE_F00D,
          32'h0, 5'd9, 1, 0, 4'd0);
    chk("sw_wdata", o_wdata, 32'hCAFE_F00D);
    chk("sw_wstrb", o_wstrb, 4'b1111);
    i_wready = 1'b1;
    i_awready = 1'b1;
    tick();
    i_wready = 1'b0;
    i_awready = 1'b0;
    i_bvalid = 1'b1;
    i_bresp = 2'b10;
    tick();
    i_bvalid = 1'b0;
    i_bresp = 2'b00;
    chk("swerr_exc", o_exception, 1'b1);
    chk("swerr_cause", o_mcause, 4'd7);
    tick();

    // Upstream exception on a load: no bus access.
    issue(1, 0, 4'b0000, 3'b010, 32'h8000_0010, 32'h0,
          32'h0, 5'd3, 1, 1, 4'd2);
    chk("upexc_no_ar", o_arvalid, 1'b0);
    chk("upexc_exc", o_exception, 1'b1);
    chk("upexc_cause", o_mcause, 4'd2);
    chk("upexc_regwen", o_reg_wen, 1'b0);
    tick();

    // Back-pressure in DONE, then same-cycle re-accept.
    i_ready = 1'b0;
    issue(0, 0, 4'b0000, 3'b000, 32'h0, 32'h0,
          32'h0000_0011, 5'd1, 1, 0, 4'd0);
    i_valid = 1'b1;
    i_result = 32'h0000_0022;
    i_reg_rd = 5'd2;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", o_valid, 1'b1);
      chk("bp_ready", o_ready, 1'b0);
      chk("bp_result", o_result, 32'h0000_0011);
      chk("bp_rd", o_reg_rd, 5'd1);
      tick();
    end
    i_ready = 1'b1;
    #1;
    chk("bp_release_ready", o_ready, 1'b1);
    tick();
    i_valid = 1'b0;
    chk("b2b_valid", o_valid, 1'b1);
    chk("b2b_result", o_result, 32'h0000_0022);
    chk("b2b_rd", o_reg_rd, 5'd2);
    tick();
    chk("b2b_idle", o_valid, 1'b0);

    // Async reset while in RD_D.
    issue(1, 0, 4'b0000, 3'b010, 32'h8000_0020, 32'h0,
          32'h0, 5'd4, 1, 0, 4'd0);
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    chk("arst_in_rdd", o_rready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rready", o_rready, 1'b0);
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_ready", o_ready, 1'b1);
    #3 rst_n = 1'b1;
    tick();
    chk("arst_post_arvalid", o_arvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
